mips_cpu_load_store_unit: RTL and testbench
===========================================

// Module: mips_cpu_load_store_unit
// PURPOSE
//  Sits between the CPU execute/memory stage and the Harvard data memory; the sole driver of the memory-side ports.
//  Converts LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW into word-only memory accesses.
//  Memory is big-endian: byte 0 = bits [31:24]. Memory reads are combinational; memory writes take effect on the clock edge.
//  Never asserts data_read and data_write together. Sub-word stores are read-modify-write over two cycles.
// PARAMETERS
//  ADDR_W  32  byte-address width of addr and data_address
//  OP_W    4   width of op
// PORTS
//  clk            in   1       system clock; all state updates on rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  req_valid      in   1       CPU request present this cycle
//  req_ready      out  1       unit can accept a request (high only in IDLE, out of reset)
//  op             in   OP_W    0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; other codes are illegal
//  addr           in   ADDR_W  byte address
//  store_data     in   32      rt value for stores
//  reg_old        in   32      current rt value, used to merge LWL/LWR results
//  load_result    out  32      registered load result
//  load_valid     out  1       1-cycle pulse: load_result is valid
//  store_done     out  1       1-cycle pulse: store committed to memory
//  addr_error     out  1       1-cycle pulse: misaligned request rejected (MISALIGN_EXC_EN only)
//  data_address   out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
//  data_read      out  1       memory read strobe
//  data_write     out  1       memory write strobe
//  data_writedata out  32      word to write
//  data_readdata  in   32      combinational read data from memory
// BEHAVIOUR
//  Reset values (async, while reset_n=0)
//   - state=IDLE; req_ready=0.
//   - load_result=0; load_valid, store_done, addr_error=0.
//   - data_read, data_write=0; data_writedata=0.
//  States: IDLE, RMW_WRITE.
//  IDLE, accepted request (req_valid & req_ready), k = addr[1:0]:
//   - Loads: data_read=1 in the same cycle. The extracted/merged value is registered at the edge; load_valid pulses the next cycle (1-cycle latency).
//     LB/LBU: byte k, sign-/zero-extended.
//     LH/LHU: half k[1] (upper half when k[1]=0), sign-/zero-extended.
//     LW: whole word.
//     LWL: (mem<<8k) | (reg_old & ((1<<8k)-1)).
//     LWR: (mem>>8(3-k)) | (reg_old & ~(32'hFFFFFFFF>>8(3-k))).
//   - SW: data_write=1 and data_writedata=store_data in the same cycle; store_done pulses the next cycle; stay in IDLE.
//   - SB/SH: data_read=1. The word is captured into rmw_buf along with store_data, k and op. Go to RMW_WRITE.
//  RMW_WRITE:
//   - req_ready=0; data_write=1.
//   - data_writedata = rmw_buf with byte k (SB) or half k[1] (SH) replaced by store_data[7:0] / store_data[15:0].
//   - Return to IDLE; store_done pulses the next cycle. Back-to-back accepted requests resume from there.
//  Illegal op: no memory access, no pulse, stay in IDLE.
//  req_valid is ignored while req_ready=0; the CPU holds its request until accepted.
//  Reset asserted in RMW_WRITE: state clears before the edge, the write is dropped, memory is unchanged.
//  At most one of load_valid / store_done / addr_error is high in any cycle.
// CONFIGURATION
//  MISALIGN_EXC_EN defined:
//   - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0: no memory access; addr_error pulses the next cycle; load_result is unchanged.
//  MISALIGN_EXC_EN undefined:
//   - addr_error is tied to 0.
//   - Offending low address bits are ignored: halfword ops use k[1] only; word ops use k=0.
//   - LWL/LWR are never misaligned in either build.
// TESTING
//  1. reset_n=0 mid-run -> all outputs 0 and req_ready=0; reset_n=1 -> req_ready=1 the next cycle.
//  2. mem[0x100]=0x8899AABB:
//     LB  addr 0x101 -> load_result=0xFFFFFF99.
//     LBU addr 0x101 -> 0x00000099.
//     LH  addr 0x102 -> 0xFFFFAABB.
//  3. mem[0x100]=0x11223344, reg_old=0xAABBCCDD:
//     LWL addr 0x101 -> 0x223344DD.
//     LWR addr 0x101 -> 0xAABB1122.
//  4. mem[0x200]=0x11223344, SB addr 0x202 with store_data=0xEE:
//     - data_read one cycle, then data_write=0x1122EE44; req_ready low for 1 cycle; store_done pulses.
//     - Reads never overlap writes throughout.
//  5. SW 0xDEADBEEF to 0x300, then LW 0x300 back-to-back -> store_done, then load_valid with 0xDEADBEEF.
//  6. LW addr 0x302:
//     - MISALIGN_EXC_EN defined: addr_error pulse, no data_read/data_write.
//     - MISALIGN_EXC_EN undefined: reads word 0x300.
//  7. reset_n pulsed low during RMW_WRITE of SH -> target word is unchanged.

Source files
------------

// File: rtl/mips_cpu_load_store_unit.sv
// rtl/mips_cpu_load_store_unit.sv - MIPS load/store unit mapping LB..SW onto a big-endian word-only data memory
// Optional MISALIGN_EXC_EN: misaligned LH/LHU/SH/LW/SW are rejected with an addr_error pulse.
module mips_cpu_load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    input  logic [31:0]       reg_old,
    output logic [31:0]       load_result,
    output logic              load_valid,
    output logic              store_done,
    output logic              addr_error,
    output logic [ADDR_W-1:0] data_address,
    output logic              data_read,
    output logic              data_write,
    output logic [31:0]       data_writedata,
    input  logic [31:0]       data_readdata
);
    localparam logic [OP_W-1:0] OP_LB  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LWL = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LWR = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(10);

    typedef enum logic {IDLE, RMW_WRITE} state_t;

    state_t            state;
    state_t            next_state;
    logic              running;
    logic              is_load;
    logic              is_sw;
    logic              is_sub;
    logic              is_half;
    logic              is_word;
    logic              legal;
    logic              misaligned;
    logic              accept;
    logic              go;
    logic [1:0]        k;
    logic [1:0]        k_eff;
    logic [1:0]        k_inv;
    logic [4:0]        sh_l;
    logic [4:0]        sh_r;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [31:0]       load_value;
    logic [31:0]       rmw_buf;
    logic [31:0]       rmw_merged;
    logic [15:0]       rmw_data;
    logic [1:0]        rmw_k;
    logic              rmw_half;
    logic [ADDR_W-3:0] rmw_word;

    always_comb begin
        is_load = 1'b0;
        is_sw   = 1'b0;
        is_sub  = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_load = 1'b1; is_word = 1'b1; end
            OP_SB:         is_sub = 1'b1;
            OP_SH:         begin is_sub = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_sw = 1'b1; is_word = 1'b1; end
            default:       ;
        endcase
    end

    assign legal = is_load | is_sw | is_sub;
    assign k     = addr[1:0];

`ifdef MISALIGN_EXC_EN
    assign misaligned = (is_half & k[0]) | (is_word & (k != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Without the exception build, the offending low address bits are simply dropped.
    assign k_eff     = is_word ? 2'b00 : (is_half ? {k[1], 1'b0} : k);
    assign k_inv     = 2'd3 - k_eff;
    assign sh_l      = {k_eff, 3'b000};
    assign sh_r      = {k_inv, 3'b000};
    assign req_ready = running & (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign go        = accept & legal & ~misaligned;

    always_comb begin
        byte_val   = 8'(data_readdata >> sh_r);
        half_val   = k_eff[1] ? data_readdata[15:0] : data_readdata[31:16];
        load_value = data_readdata;
        case (op)
            OP_LB:   load_value = {{24{byte_val[7]}}, byte_val};
            OP_LBU:  load_value = {24'h000000, byte_val};
            OP_LH:   load_value = {{16{half_val[15]}}, half_val};
            OP_LHU:  load_value = {16'h0000, half_val};
            OP_LWL:  load_value = (data_readdata << sh_l) | (reg_old & ((32'd1 << sh_l) - 32'd1));
            OP_LWR:  load_value = (data_readdata >> sh_r) | (reg_old & ~(32'hFFFF_FFFF >> sh_r));
            default: ;
        endcase
    end

    always_comb begin
        rmw_merged = rmw_buf;
        if (rmw_half) begin
            if (rmw_k[1]) rmw_merged[15:0] = rmw_data;
            else          rmw_merged[31:16] = rmw_data;
        end else begin
            case (rmw_k)
                2'd0:    rmw_merged[31:24] = rmw_data[7:0];
                2'd1:    rmw_merged[23:16] = rmw_data[7:0];
                2'd2:    rmw_merged[15:8]  = rmw_data[7:0];
                default: rmw_merged[7:0]   = rmw_data[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state     = state;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_writedata = 32'h0;
        data_address   = {addr[ADDR_W-1:2], 2'b00};
        case (state)
            IDLE: begin
                if (go) begin
                    data_read = is_load | is_sub;
                    if (is_sw) begin
                        data_write     = 1'b1;
                        data_writedata = store_data;
                    end
                    if (is_sub) next_state = RMW_WRITE;
                end
            end
            RMW_WRITE: begin
                data_write     = 1'b1;
                data_writedata = rmw_merged;
                data_address   = {rmw_word, 2'b00};
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running     <= 1'b0;
            load_result <= 32'h0;
            load_valid  <= 1'b0;
            store_done  <= 1'b0;
            rmw_buf     <= 32'h0;
            rmw_data    <= 16'h0;
            rmw_k       <= 2'b00;
            rmw_half    <= 1'b0;
            rmw_word    <= '0;
        end else begin
            running    <= 1'b1;
            load_valid <= go & is_load;
            store_done <= (go & is_sw) | (state == RMW_WRITE);
            if (go & is_load) load_result <= load_value;
            if (go & is_sub) begin
                rmw_buf  <= data_readdata;
                rmw_data <= store_data[15:0];
                rmw_k    <= k_eff;
                rmw_half <= is_half;
                rmw_word <= addr[ADDR_W-1:2];
            end
        end
    end

`ifdef MISALIGN_EXC_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) addr_error <= 1'b0;
        else          addr_error <= accept & legal & misaligned;
    end
`else
    assign addr_error = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_load_store_unit.sv
// tb/tb_mips_cpu_load_store_unit.sv - directed self-checking bench for mips_cpu_load_store_unit
module tb_mips_cpu_load_store_unit;
    localparam logic [3:0] LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4;
    localparam logic [3:0] LWL = 4'd5, LWR = 4'd6, SB = 4'd8, SH = 4'd9, SW = 4'd10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] reg_old = 32'h0;
    logic [31:0] load_result;
    logic        load_valid;
    logic        store_done;
    logic        addr_error;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    int n_checks = 0;
    int n_fail = 0;
    int overlap_cnt = 0;
    int multi_cnt = 0;

    logic        acc_read, acc_write, acc_store_done;
    logic [31:0] acc_wdata, acc_addr;

    logic [31:0] mem [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = 10'd0;
    logic [31:0] bd_data = 32'h0;

    mips_cpu_load_store_unit #(.ADDR_W(32), .OP_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .addr(addr), .store_data(store_data), .reg_old(reg_old),
        .load_result(load_result), .load_valid(load_valid), .store_done(store_done),
        .addr_error(addr_error), .data_address(data_address), .data_read(data_read),
        .data_write(data_write), .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    always #5 clk = ~clk;

    assign data_readdata = mem[data_address[11:2]];

    always @(posedge clk) begin
        if (data_write) mem[data_address[11:2]] <= data_writedata;
        else if (bd_we) mem[bd_idx] <= bd_data;
    end

    always @(negedge clk) begin
        if (data_read && data_write) overlap_cnt++;
        if (int'(load_valid) + int'(store_done) + int'(addr_error) > 1) multi_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_poke(input logic [9:0] idx, input logic [31:0] d);
        bd_idx = idx;
        bd_data = d;
        bd_we = 1'b1;
        step();
        bd_we = 1'b0;
    endtask

    task automatic do_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] sd, input logic [31:0] ro);
        int n = 0;
        op = o; addr = a; store_data = sd; reg_old = ro; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL req_accept: req_ready=%b expected 1", req_ready); end
        acc_read = data_read; acc_write = data_write; acc_wdata = data_writedata;
        acc_store_done = store_done; acc_addr = data_address;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready, load_valid, store_done, addr_error, data_read, data_write} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000", {req_ready, load_valid, store_done, addr_error, data_read, data_write});
        end
        n_checks++;
        if (load_result !== 32'h0) begin n_fail++; $display("FAIL reset_load_result: got %h expected 00000000", load_result); end
        n_checks++;
        if (data_writedata !== 32'h0) begin n_fail++; $display("FAIL reset_writedata: got %h expected 00000000", data_writedata); end
        step();
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_early: got %b expected 0", req_ready); end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", req_ready); end
        step();
    endtask

    task automatic test_loads();
        logic [3:0]  ops [8] = '{LB, LBU, LH, LHU, LW, LB, LBU, LH};
        logic [31:0] adr [8] = '{32'h101, 32'h101, 32'h102, 32'h100, 32'h100, 32'h103, 32'h100, 32'h100};
        logic [31:0] exp [8] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFFAABB, 32'h00008899,
                                 32'h8899AABB, 32'hFFFFFFBB, 32'h00000088, 32'hFFFF8899};
        mem_poke(10'h040, 32'h8899AABB);
        for (int i = 0; i < 8; i++) begin
            do_req(ops[i], adr[i], 32'h0, 32'h0);
            n_checks++;
            if ({acc_read, acc_write} !== 2'b10) begin n_fail++; $display("FAIL load_strobe[%0d]: got %b expected 10", i, {acc_read, acc_write}); end
            @(negedge clk);
            n_checks++;
            if (load_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid[%0d]: got %b expected 1", i, load_valid); end
            n_checks++;
            if (load_result !== exp[i]) begin n_fail++; $display("FAIL load_result[%0d]: got %h expected %h", i, load_result, exp[i]); end
            step();
        end
    endtask

    task automatic test_lwl_lwr();
        logic [3:0]  ops [8] = '{LWL, LWR, LWL, LWR, LWL, LWR, LWL, LWR};
        logic [31:0] adr [8] = '{32'h101, 32'h101, 32'h100, 32'h103, 32'h103, 32'h100, 32'h102, 32'h102};
        logic [31:0] exp [8] = '{32'h223344DD, 32'hAABB1122, 32'h11223344, 32'h11223344,
                                 32'h44BBCCDD, 32'hAABBCC11, 32'h3344CCDD, 32'hAA112233};
        mem_poke(10'h040, 32'h11223344);
        for (int i = 0; i < 8; i++) begin
            do_req(ops[i], adr[i], 32'h0, 32'hAABBCCDD);
            @(negedge clk);
            n_checks++;
            if ({load_valid, load_result} !== {1'b1, exp[i]}) begin
                n_fail++; $display("FAIL merge[%0d]: got valid=%b %h expected 1 %h", i, load_valid, load_result, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_sub_store();
        logic [3:0]  ops [3] = '{SB, SH, SB};
        logic [31:0] adr [3] = '{32'h202, 32'h200, 32'h203};
        logic [31:0] sd  [3] = '{32'h000000EE, 32'h00005566, 32'h123456AB};
        logic [31:0] exp [3] = '{32'h1122EE44, 32'h5566EE44, 32'h5566EEAB};
        mem_poke(10'h080, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            do_req(ops[i], adr[i], sd[i], 32'h0);
            n_checks++;
            if ({acc_read, acc_write, acc_addr} !== {2'b10, 32'h200}) begin
                n_fail++; $display("FAIL rmw_read[%0d]: got rd=%b wr=%b addr=%h expected 1 0 00000200", i, acc_read, acc_write, acc_addr);
            end
            @(negedge clk);
            n_checks++;
            if ({data_write, data_read, req_ready, data_address} !== {3'b100, 32'h200}) begin
                n_fail++; $display("FAIL rmw_write_strobe[%0d]: got wr=%b rd=%b rdy=%b addr=%h expected 1 0 0 00000200",
                                   i, data_write, data_read, req_ready, data_address);
            end
            n_checks++;
            if (data_writedata !== exp[i]) begin n_fail++; $display("FAIL rmw_wdata[%0d]: got %h expected %h", i, data_writedata, exp[i]); end
            @(negedge clk);
            n_checks++;
            if ({store_done, req_ready} !== 2'b11) begin n_fail++; $display("FAIL rmw_done[%0d]: got done=%b rdy=%b expected 1 1", i, store_done, req_ready); end
            n_checks++;
            if (mem[10'h080] !== exp[i]) begin n_fail++; $display("FAIL rmw_mem[%0d]: got %h expected %h", i, mem[10'h080], exp[i]); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_req(SW, 32'h300, 32'hDEADBEEF, 32'h0);
        n_checks++;
        if ({acc_read, acc_write, acc_wdata} !== {2'b01, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL sw_write: got rd=%b wr=%b data=%h expected 0 1 deadbeef", acc_read, acc_write, acc_wdata);
        end
        do_req(LW, 32'h300, 32'h0, 32'h0);
        n_checks++;
        if ({acc_store_done, acc_read} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_store_done: got done=%b rd=%b expected 1 1", acc_store_done, acc_read);
        end
        @(negedge clk);
        n_checks++;
        if ({load_valid, store_done, load_result} !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL b2b_load: got valid=%b done=%b %h expected 1 0 deadbeef", load_valid, store_done, load_result);
        end
        step();
    endtask

    task automatic test_misalign();
        logic [31:0] keep;
        mem_poke(10'h0C0, 32'h01234567);
        do_req(LW, 32'h302, 32'h0, 32'h0);
        @(negedge clk);
`ifdef MISALIGN_EXC_EN
        n_checks++;
        if ({acc_read, acc_write} !== 2'b00) begin n_fail++; $display("FAIL misalign_lw_access: got %b expected 00", {acc_read, acc_write}); end
        n_checks++;
        if ({addr_error, load_valid, load_result} !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL misalign_lw: got err=%b valid=%b %h expected 1 0 deadbeef", addr_error, load_valid, load_result);
        end
        step();
        do_req(LH, 32'h101, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({addr_error, load_valid, acc_read} !== 3'b100) begin
            n_fail++; $display("FAIL misalign_lh: got err=%b valid=%b rd=%b expected 1 0 0", addr_error, load_valid, acc_read);
        end
        keep = 32'hDEADBEEF;
`else
        n_checks++;
        if ({acc_read, acc_addr} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL lw_low_bits: got rd=%b addr=%h expected 1 00000300", acc_read, acc_addr); end
        n_checks++;
        if ({addr_error, load_valid, load_result} !== {2'b01, 32'h01234567}) begin
            n_fail++; $display("FAIL lw_unaligned: got err=%b valid=%b %h expected 0 1 01234567", addr_error, load_valid, load_result);
        end
        step();
        do_req(LH, 32'h101, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({addr_error, load_valid, load_result} !== {2'b01, 32'h00001122}) begin
            n_fail++; $display("FAIL lh_unaligned: got err=%b valid=%b %h expected 0 1 00001122", addr_error, load_valid, load_result);
        end
        keep = 32'h00001122;
`endif
        step();
        do_req(4'd7, 32'h300, 32'h0, 32'h0);
        n_checks++;
        if ({acc_read, acc_write} !== 2'b00) begin n_fail++; $display("FAIL illegal_access: got %b expected 00", {acc_read, acc_write}); end
        @(negedge clk);
        n_checks++;
        if ({load_valid, store_done, addr_error, load_result} !== {3'b000, keep}) begin
            n_fail++; $display("FAIL illegal_pulse: got %b %h expected 000 %h", {load_valid, store_done, addr_error}, load_result, keep);
        end
        step();
    endtask

    task automatic test_reset_midrun();
        reset_n = 1'b0;
        req_valid = 1'b1; op = LW; addr = 32'h100;
        #1;
        n_checks++;
        if ({req_ready, load_valid, store_done, addr_error, data_read, data_write} !== 6'b0) begin
            n_fail++; $display("FAIL midrun_flags: got %b expected 000000", {req_ready, load_valid, store_done, addr_error, data_read, data_write});
        end
        n_checks++;
        if ({load_result, data_writedata} !== 64'h0) begin
            n_fail++; $display("FAIL midrun_data: got %h %h expected 0 0", load_result, data_writedata);
        end
        step();
        req_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL midrun_ready_early: got %b expected 0", req_ready); end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_ready: got %b expected 1", req_ready); end
        step();
    endtask

    task automatic test_rmw_reset();
        mem_poke(10'h090, 32'hA1B2C3D4);
        do_req(SH, 32'h242, 32'h00007777, 32'h0);
        n_checks++;
        if (data_write !== 1'b1) begin n_fail++; $display("FAIL rmw_pending: got %b expected 1", data_write); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({data_write, req_ready} !== 2'b00) begin n_fail++; $display("FAIL rmw_reset_drop: got %b expected 00", {data_write, req_ready}); end
        step();
        reset_n = 1'b1;
        n_checks++;
        if (mem[10'h090] !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL rmw_reset_mem: got %h expected a1b2c3d4", mem[10'h090]); end
        step();
        do_req(SH, 32'h242, 32'h00007777, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({store_done, mem[10'h090]} !== {1'b1, 32'hA1B27777}) begin
            n_fail++; $display("FAIL rmw_after_reset: got done=%b %h expected 1 a1b27777", store_done, mem[10'h090]);
        end
        step();
    endtask

    task automatic test_invariants();
        n_checks++;
        if (overlap_cnt !== 0) begin n_fail++; $display("FAIL read_write_overlap: got %0d cycles expected 0", overlap_cnt); end
        n_checks++;
        if (multi_cnt !== 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d cycles expected 0", multi_cnt); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_lwl_lwr();
        test_sub_store();
        test_back_to_back();
        test_misalign();
        test_reset_midrun();
        test_rmw_reset();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
